// File: rtl/flu_wb_arbiter.sv
// Writeback collector: one FIFO per fixed-latency producer, one head selected per cycle
// for the scoreboard write port. Define FLU_WB_RR_EN for round-robin instead of fixed priority.
module flu_wb_arbiter #(
  parameter int NR_CH         = 4,
  parameter int DEPTH         = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic                           flush_i,
  input  logic [NR_CH-1:0]               ch_valid_i,
  output logic [NR_CH-1:0]               ch_ready_o,
  input  logic [NR_CH*XLEN-1:0]          ch_result_i,
  input  logic [NR_CH*TRANS_ID_BITS-1:0] ch_trans_id_i,
  input  logic [NR_CH-1:0]               ch_ex_valid_i,
  output logic                           wb_valid_o,
  input  logic                           wb_ready_i,
  output logic [XLEN-1:0]                wb_result_o,
  output logic [TRANS_ID_BITS-1:0]       wb_trans_id_o,
  output logic                           wb_ex_valid_o,
  output logic [$clog2(NR_CH)-1:0]       wb_ch_o,
  output logic                           pending_o
);

  localparam int CH_W  = $clog2(NR_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]          res_mem [NR_CH][DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem  [NR_CH][DEPTH];
  logic                     ex_mem  [NR_CH][DEPTH];

  logic [PTR_W-1:0] wr_ptr_q [NR_CH];
  logic [PTR_W-1:0] rd_ptr_q [NR_CH];
  logic [CNT_W-1:0] cnt_q    [NR_CH];

  logic [NR_CH-1:0] empty;
  logic [NR_CH-1:0] full;
  logic [NR_CH-1:0] push;
  logic [NR_CH-1:0] pop;
  logic             grant_valid;
  logic [CH_W-1:0]  grant_idx;
  logic             drop_all;

  assign drop_all = clr_i | flush_i;

  // Ready comes from registered occupancy only, so a same-cycle pop never opens a slot.
  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    pop   = '0;
    for (int c = 0; c < NR_CH; c++) begin
      empty[c] = (cnt_q[c] == '0);
      full[c]  = (cnt_q[c] == CNT_W'(DEPTH));
      push[c]  = ch_valid_i[c] & ~full[c];
      pop[c]   = wb_valid_o & wb_ready_i & (grant_idx == CH_W'(c));
    end
  end

  assign ch_ready_o = ~full;
  assign pending_o  = |(~empty);

`ifdef FLU_WB_RR_EN
  logic [CH_W-1:0] rr_q;

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NR_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NR_CH) idx = idx - NR_CH;
      if (!grant_valid && !empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  // Pointer only moves on a real pop, so the grant holds steady while the scoreboard stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (clr_i) begin
      rr_q <= '0;
    end else if (!flush_i && (|pop)) begin
      if (grant_idx == CH_W'(NR_CH - 1)) rr_q <= '0;
      else                               rr_q <= grant_idx + CH_W'(1);
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NR_CH; i++) begin
      if (!grant_valid && !empty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end
`endif

  // Idle outputs are silenced so stale FIFO contents never reach the scoreboard bus.
  always_comb begin
    wb_valid_o    = grant_valid;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_ex_valid_o = 1'b0;
    wb_ch_o       = '0;
    if (grant_valid) begin
      wb_result_o   = res_mem[grant_idx][rd_ptr_q[grant_idx]];
      wb_trans_id_o = id_mem[grant_idx][rd_ptr_q[grant_idx]];
      wb_ex_valid_o = ex_mem[grant_idx][rd_ptr_q[grant_idx]];
      wb_ch_o       = grant_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NR_CH; c++) begin
      if (push[c]) begin
        res_mem[c][wr_ptr_q[c]] <= ch_result_i[c*XLEN +: XLEN];
        id_mem[c][wr_ptr_q[c]]  <= ch_trans_id_i[c*TRANS_ID_BITS +: TRANS_ID_BITS];
        ex_mem[c][wr_ptr_q[c]]  <= ch_ex_valid_i[c];
      end
    end
  end

  // Flush/clear empties every FIFO and discards that cycle's pushes and pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NR_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else if (drop_all) begin
      for (int c = 0; c < NR_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NR_CH; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        if (push[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        else if (pop[c] && !push[c]) cnt_q[c] <= cnt_q[c] - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/flu_wb_arbiter.md
Name: flu_wb_arbiter

Overview:
- Parametrised writeback collector for the fixed-latency unit (FLU) path.
- Generalises the single shared FLU result port to NR_CH independent producers (ALU, CSR, mult, plus future units), each with its own FIFO.
- Producers can retire results in the same cycle without issue-side collision avoidance.
- Selects one head entry per cycle and drives the single scoreboard write port.

Parameters:
- NR_CH, 4, number of producer channels (>=2)
- DEPTH, 2, entries per channel FIFO (power of two, >=2)
- XLEN, 64, result width
- TRANS_ID_BITS, 3, scoreboard transaction id width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- clr_i  in  1  synchronous clear, active high
- flush_i  in  1  pipeline flush, active high
- ch_valid_i  in  NR_CH  per-channel result valid
- ch_ready_o  out  NR_CH  per-channel FIFO can accept
- ch_result_i  in  NR_CH*XLEN  per-channel result
- ch_trans_id_i  in  NR_CH*TRANS_ID_BITS  per-channel scoreboard id
- ch_ex_valid_i  in  NR_CH  per-channel exception flag
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  scoreboard accepts writeback
- wb_result_o  out  XLEN  selected result
- wb_trans_id_o  out  TRANS_ID_BITS  selected id
- wb_ex_valid_o  out  1  selected exception flag
- wb_ch_o  out  $clog2(NR_CH)  index of granted channel
- pending_o  out  1  any FIFO non-empty

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset: all FIFOs empty, pointers 0, arbiter pointer 0.
- Reset output values: wb_valid_o=0, pending_o=0, ch_ready_o=all 1, wb_result_o=0, wb_trans_id_o=0, wb_ex_valid_o=0, wb_ch_o=0.
- Push:
  - Occurs when ch_valid_i[c] & ch_ready_o[c] at the clock edge.
  - ch_ready_o[c] = ~full[c], from registered occupancy only. A same-cycle pop does not raise ready.
  - ch_valid_i while not ready: the beat is dropped. Producers must hold issue; the bench asserts this never happens.
- Latency: no bypass. A beat pushed at edge t is visible at wb_* no earlier than the cycle after edge t, i.e. minimum 1 cycle.
- Output:
  - wb_valid_o = OR of non-empty heads.
  - wb_* are combinational from the granted head.
  - When wb_valid_o=0, wb_result_o, wb_trans_id_o, wb_ex_valid_o and wb_ch_o are driven 0 (data silencing).
- Pop: the granted head is popped when wb_valid_o & wb_ready_i. At most one pop per cycle.
- Push and pop on the same channel in the same cycle: both take effect and occupancy is unchanged. Only reachable when not full.
- Pointers: wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- Arbitration: fixed priority, lowest index wins (see Optional Feature for round-robin).
- flush_i:
  - On the next edge, all FIFOs are empty.
  - Pushes and pops in the flush cycle are discarded.
  - The arbiter pointer is kept.
  - wb_valid_o may be 1 during the flush cycle; the scoreboard ignores it under flush.
- clr_i: same as flush_i, and additionally resets the arbiter pointer to 0. clr_i has priority over flush_i.
- pending_o: combinational OR of non-empty. Used for no-pending checks by the issue logic.

Optional Feature:
- Macro: FLU_WB_RR_EN.
- Defined:
  - Round-robin arbitration with registered pointer rr_q.
  - Search starts at channel rr_q and wraps to rr_q-1.
  - On each pop, rr_q <= granted+1 mod NR_CH.
  - rr_q is unchanged when there is no pop, including wb_ready_i=0, so the grant is stable while stalled.
- Undefined:
  - Fixed priority, lowest index wins.
  - rr_q is not instantiated.
  - clr_i affects only the FIFOs.

Test Plan:
- Reset release, no stimulus -> wb_valid_o=0, pending_o=0, ch_ready_o=4'b1111 for 4 cycles.
- Single push ch2 (result=64'hDEAD, id=5), wb_ready_i=1 -> next cycle: wb_valid_o=1, wb_ch_o=2, wb_trans_id_o=5. Cycle after: empty.
- Simultaneous push ch0 (id=1), ch1 (id=2), ch3 (id=3), wb_ready_i=1:
  - Fixed priority -> ids 1,2,3 on consecutive cycles.
  - With FLU_WB_RR_EN and rr_q=2 initially -> ids 3,1,2.
- wb_ready_i=0, push ch1 twice (DEPTH=2) -> ch_ready_o[1]=0. Raise wb_ready_i -> first entry popped, ch_ready_o[1]=1 the following cycle, FIFO order preserved.
- Fill ch0 and ch1, assert flush_i one cycle with ch0 push -> next cycle: pending_o=0, wb_valid_o=0, ch_ready_o=all 1. Flushed push never appears.
- Pointer wrap: 5 push/pop pairs on ch3 with ids 0..4 -> outputs ids 0..4 in order, no loss or duplication.
